// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, 2-of-3 mid-bit majority vote and stop-bit framing check.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic          sync1_q, sync2_q, dly_q, s7_q, s8_q;
  logic [DW-1:0] div_cnt_q;
  logic [3:0]    sample_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          start_edge, tick, vote_tick, vote;
  assign start_edge = dly_q & ~sync2_q;
  assign tick       = div_cnt_q == DW'(DIV - 1);
  assign vote_tick  = tick && sample_cnt_q == 4'd9;
  assign vote       = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      dly_q        <= 1'b1;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      div_cnt_q    <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_busy      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      dly_q     <= sync2_q;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) sample_cnt_q <= sample_cnt_q + 1'b1;
      if (tick && sample_cnt_q == 4'd7) s7_q <= sync2_q;
      if (tick && sample_cnt_q == 4'd8) s8_q <= sync2_q;
      case (state_q)
        IDLE: if (start_edge) begin
          // restart the tick grid on the edge so votes land mid-bit
          state_q      <= START;
          rx_busy      <= 1'b1;
          div_cnt_q    <= '0;
          sample_cnt_q <= '0;
        end
        START: if (vote_tick) begin
          state_q   <= vote ? IDLE : DATA;
          rx_busy   <= ~vote;
          bit_cnt_q <= '0;
        end
        DATA: if (vote_tick) begin
          shift_q   <= {vote, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_q <= STOP;
        end
        STOP: if (vote_tick) begin
          state_q   <= IDLE;
          rx_busy   <= 1'b0;
          rx_done   <= vote;
          frame_err <= ~vote;
          if (vote) rx_data <= shift_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx at a scaled baud (DIV=4, 64 clocks per bit).
module tb_uart_rx;
  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 1_562_500;
  localparam int BIT       = 640;
  localparam int NRAND     = 40;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_err;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;
  int         checks = 0, errors = 0;
  int         done_cnt = 0, err_cnt = 0, pulse_bad = 0;
  int         d0, e0;
  logic       prev_done = 1'b0, prev_err = 1'b0;
  longint     last_done_t = 0, t0, lat;
  logic [7:0] got_q[$];
  logic [7:0] sent[NRAND];
  logic [7:0] part;
  vec_t       vecs[6];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
    .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_done) begin
        done_cnt++;
        last_done_t = $time;
        got_q.push_back(rx_data);
      end
      if (frame_err) err_cnt++;
      if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_err)) pulse_bad++;
      prev_done = rx_done;
      prev_err  = frame_err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #BIT;
    end
    rx = stop;
    #BIT;
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b1, 8'h41, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'h41, 0, 1};
    vecs[2] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vecs[4] = '{8'hC3, 1'b0, 8'h01, 0, 1};
    vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1, 0};
    #15;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_done", rx_done, 0);
    check("reset_rx_busy", rx_busy, 0);
    check("reset_frame_err", frame_err, 0);
    #5 rst = 1'b1;
    #(2 * BIT);
    // first frame: latency from falling edge and busy mid-frame
    t0 = $time;
    d0 = done_cnt;
    fork
      send_frame(8'h41, 1'b1);
      begin
        #(5 * BIT);
        check("busy_mid_frame", rx_busy, 1);
      end
    join
    #BIT;
    lat = last_done_t - t0;
    check("first_done_count", done_cnt - d0, 1);
    check("first_rx_data", rx_data, 8'h41);
    check("first_latency_in_window", (lat >= 6170 && lat <= 6210), 1);
    if (lat < 6170 || lat > 6210) $display("FAIL latency: got %0d expected 6190", lat);
    check("first_busy_after", rx_busy, 0);
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      rx = 1'b1;
      #(2 * BIT);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), rx_busy, 0);
    end
    // back-to-back frames, one stop bit each
    got_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    #(2 * BIT);
    check("b2b_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("b2b_0", got_q[0], 8'h00);
      check("b2b_1", got_q[1], 8'hFF);
      check("b2b_2", got_q[2], 8'hA5);
    end
    // short low glitch is a false start
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    #100;
    check("glitch_busy_set", rx_busy, 1);
    #100;
    rx = 1'b1;
    #(2 * BIT);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy_clear", rx_busy, 0);
    // bad stop bit followed by a held-low line
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    #(3 * BIT);
    check("break_err", err_cnt - e0, 1);
    check("break_done", done_cnt - d0, 0);
    check("break_busy", rx_busy, 0);
    check("break_data_kept", rx_data, 8'hA5);
    rx = 1'b1;
    #BIT;
    send_frame(8'h66, 1'b1);
    #(2 * BIT);
    check("after_break_done", done_cnt - d0, 1);
    check("after_break_data", rx_data, 8'h66);
    // reset during data bit 4 of 0x5A
    d0 = done_cnt;
    e0 = err_cnt;
    part = 8'h5A;
    rx = 1'b0;
    #BIT;
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      #BIT;
    end
    rx = part[4];
    #(BIT / 2);
    rst = 1'b0;
    #3;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_done", rx_done, 0);
    check("midrst_rx_busy", rx_busy, 0);
    check("midrst_frame_err", frame_err, 0);
    rx = 1'b1;
    #(BIT + 7);
    rst = 1'b1;
    #(2 * BIT);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    send_frame(8'h96, 1'b1);
    #(2 * BIT);
    check("postrst_done", done_cnt - d0, 1);
    check("postrst_data", rx_data, 8'h96);
    // loopback-style stream of random bytes
    got_q.delete();
    for (int i = 0; i < NRAND; i++) sent[i] = 8'($urandom_range(255));
    for (int i = 0; i < NRAND; i++) send_frame(sent[i], 1'b1);
    #(2 * BIT);
    check("rand_count", got_q.size(), NRAND);
    for (int i = 0; i < NRAND; i++)
      if (i < got_q.size()) check($sformatf("rand_%0d", i), got_q[i], sent[i]);
    check("pulse_shape", pulse_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive half of UART_top, and the counterpart of the existing transmitter. It takes the asynchronous serial line `rx` and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) using an internal 16x oversampling tick.
- Delivers each good byte on `rx_data` with a one-cycle `rx_done` strobe.
- Flags bad stop bits on `frame_err`.
- Drops into UART_top's `rx`/`rx_data`/`rx_done` ports; the existing TX can be looped back to it.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16, must not be overridden.
- DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (integer floor; 651 at defaults), clocks per sample tick. Effective bit period = 16*DIV = 10416 clocks.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last correctly received byte; held until the next good frame.
- rx_done  output  1  one-clk pulse: rx_data just updated.
- rx_busy  output  1  high from start-edge detection until return to IDLE.
- frame_err  output  1  one-clk pulse: stop bit sampled low.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - rx_data=8'h00; rx_done=0; rx_busy=0; frame_err=0.
  - Both synchronizer flops and the edge-detect flop = 1 (idle line).
  - State=IDLE; tick counter and bit counter = 0.
- Input path:
  - 2-FF synchronizer on rx, then a 1-FF delayed copy for edge detection.
  - Start edge = delayed copy 1 and synchronized value 0.
- Tick generator:
  - div_cnt counts 0..DIV-1 and emits `tick` when div_cnt==DIV-1.
  - Cleared to 0 on start-edge detection so sampling aligns to the edge.
- sample_cnt (4 bits) counts ticks within a bit, 0..15, wrapping 15->0.
- Majority vote: each bit value is the 2-of-3 majority of the synchronized line at the ticks where sample_cnt = 7, 8, 9. The decision is taken on the sample_cnt==9 tick.
- IDLE:
  - rx_busy=0.
  - On start edge: go to START, rx_busy=1, div_cnt=0, sample_cnt=0.
  - A level-low line without an edge does not start a frame (break/stuck-low protection).
- START, at the vote:
  - Vote=1: false start; go to IDLE with no pulses.
  - Vote=0: go to DATA with bit_cnt=0.
  - On leaving START, sample_cnt keeps counting to 15, so subsequent votes land mid-bit.
- DATA:
  - Each vote shifts into a shift register, LSB first (bit_cnt=0 is rx_data[0]).
  - After the vote with bit_cnt=7, go to STOP.
- STOP, at the vote:
  - Vote=1: rx_data<=shift register and rx_done=1 for exactly one clk, on the cycle after the vote.
  - Vote=0: frame_err=1 for one clk; rx_data unchanged; rx_done stays 0.
  - Either way go to IDLE immediately, without waiting for the remainder of the stop bit. A start edge arriving ≥ half a bit after stop-bit centre is therefore caught, and back-to-back frames are received.
- Latency: rx_done rises 9 bit periods + 10 ticks (≈ 9.6*10416 clocks) after the synchronized start edge, plus 2-3 clocks of synchronizer delay.
- rx_done and frame_err are mutually exclusive and never high more than one cycle.
- Reset mid-frame: everything returns to reset values at once and the partial byte is discarded. After release, a frame already in progress is not recognised until a fresh falling edge occurs.
- After a frame error on a line held low (break): no new frame starts until the line returns high and falls again.
- Baud mismatch tolerance: integer DIV truncation error is below 0.01% at defaults. A mismatch is a wrong byte (or a frame error), not a hang.

Test Plan:
1. Reset low 20 ns, then drive 8N1 frame 0x41 at BIT_PERIOD=104160 ns. Required: rx_data=0x41, single rx_done pulse ≈ 9.6 bit periods after the falling edge, frame_err=0, rx_busy high over the frame.
2. Back-to-back frames 0x00, 0xFF, 0xA5 with a single stop bit each and no idle gap. Required: three rx_done pulses with rx_data = 0x00, 0xFF, 0xA5 in order.
3. rx low glitch of 20000 ns (< half a bit), then high. Required: no rx_done, no frame_err, rx_busy returns to 0, state back to IDLE.
4. Frame 0x3C with stop bit driven low, after a prior good 0x41. Required: one frame_err pulse, no rx_done, rx_data stays 0x41. Holding rx low afterwards starts no new frame until a high-then-low transition.
5. Assert rst low during data bit 4 of frame 0x5A, release, then send 0x96. Required: outputs at reset values during reset; 0x5A is never reported; 0x96 is received correctly.
6. Loopback: UART_top tx fed to rx, 256 $random bytes via tx_start. Required: every rx_data equals the sent byte, pass_count=256, fail_count=0.
